// File: rtl/sipo_ctrl_pkg.sv
// Shared types and default sizing for the serial-in/parallel-out receive controller.
package sipo_ctrl_pkg;

  localparam int SIPO_WIDTH_DEF = 32;
  localparam int SIPO_CNT_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } sipo_state_e;

endpackage

// File: rtl/sipo_rx_controller_if.sv
// Serial input side plus parallel valid/ready output side of the receive controller.
// The controller uses the slave modport; the serial source / consumer uses master.
interface sipo_rx_controller_if #(
  parameter int WIDTH = 32
);
  logic             serial_in;
  logic             bit_en;
  logic             frame_start;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  modport master (
    output serial_in, bit_en, frame_start, word_ready,
    input  word_out, word_valid, busy, overrun, parity_err
  );

  modport slave (
    input  serial_in, bit_en, frame_start, word_ready,
    output word_out, word_valid, busy, overrun, parity_err
  );
endinterface

// File: rtl/sipo_shift_core.sv
// Enable-gated left-shift register; new bits enter at bit 0 so the first bit ends up as MSB.
module sipo_shift_core #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next shift value: clear wins over shifting
  always_comb begin
    sr_d = sr_q;
    if (clr) begin
      sr_d = {WIDTH{1'b0}};
    end else if (en) begin
      sr_d = {sr_q[WIDTH-2:0], din};
    end else begin
      sr_d = sr_q;
    end
  end

  // Shift register storage
  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q <= {WIDTH{1'b0}};
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q;

endmodule

// File: rtl/sipo_rx_controller.sv
// Frame sequencer, bit counter and one-word holding buffer for the SIPO receiver.
// Optional even-parity bit after the data is enabled by defining SIPO_PARITY_CHECK_EN.
module sipo_rx_controller
  import sipo_ctrl_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH_DEF,
  parameter int CNT_W = SIPO_CNT_W_DEF
) (
  input logic                 clock,
  input logic                 reset,
  sipo_rx_controller_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  sipo_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overrun_q, overrun_d;
  logic             sr_clr_s;
  logic             sr_en_s;
  logic [WIDTH-1:0] sr_s;
`ifdef SIPO_PARITY_CHECK_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;

  function automatic logic parity_mismatch(input logic [WIDTH-1:0] data, input logic par);
    return ^{data, par};
  endfunction
`endif

  sipo_shift_core #(.WIDTH(WIDTH)) u_shift (
    .clock (clock),
    .reset (reset),
    .clr   (sr_clr_s),
    .en    (sr_en_s),
    .din   (bus.serial_in),
    .q     (sr_s)
  );

  // Next-state, counter and holding-buffer logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    overrun_d = 1'b0;
    sr_clr_s  = 1'b0;
    sr_en_s   = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
    par_d     = par_q;
    perr_d    = perr_q;
`endif
    if (valid_q && bus.word_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          state_d  = SHIFT;
          cnt_d    = {CNT_W{1'b0}};
          sr_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (bus.frame_start) begin
          cnt_d    = {CNT_W{1'b0}};
          sr_clr_s = 1'b1;
        end else if (bus.bit_en) begin
          sr_en_s = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q == LAST_CNT) begin
`ifdef SIPO_PARITY_CHECK_EN
            state_d = PAR;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = SHIFT;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      PAR: begin
        if (bus.frame_start) begin
          state_d  = SHIFT;
          cnt_d    = {CNT_W{1'b0}};
          sr_clr_s = 1'b1;
        end else if (bus.bit_en) begin
`ifdef SIPO_PARITY_CHECK_EN
          par_d   = bus.serial_in;
`endif
          state_d = DONE;
        end else begin
          state_d = PAR;
        end
      end
      DONE: begin
        // A full buffer not being drained this cycle keeps the old word
        if (valid_q && !bus.word_ready) begin
          overrun_d = 1'b1;
        end else begin
          word_d  = sr_s;
          valid_d = 1'b1;
`ifdef SIPO_PARITY_CHECK_EN
          perr_d  = parity_mismatch(sr_s, par_q);
`endif
        end
        if (bus.frame_start) begin
          state_d  = SHIFT;
          cnt_d    = {CNT_W{1'b0}};
          sr_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      word_q    <= {WIDTH{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef SIPO_PARITY_CHECK_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
`ifdef SIPO_PARITY_CHECK_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_rx_controller.sv
// Scoreboard bench for sipo_rx_controller: stimulus pushes expected words, a negedge
// monitor pops and compares on every accepted handshake.
module tb_sipo_rx_controller;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] word;
    logic         perr;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  sipo_rx_controller_if #(.WIDTH(W)) bus();

  sipo_rx_controller #(.WIDTH(W), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int           checks       = 0;
  int           errors       = 0;
  int           overrun_seen = 0;
  int           busy_low     = 0;
  exp_t         exp_q[$];
  exp_t         mon_e;
  logic         hold_prev    = 1'b0;
  logic [W-1:0] hold_word    = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic exp_perr(input logic [W-1:0] w, input logic p);
`ifdef SIPO_PARITY_CHECK_EN
    return ^{w, p};
`else
    return p & 1'b0;
`endif
  endfunction

  // Monitor: overrun counting, hold stability and scoreboard pops
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_prev = 1'b0;
      end else begin
        if (bus.overrun) overrun_seen++;
        if (hold_prev && bus.word_valid) check("hold_stable", bus.word_out, hold_word);
        if (bus.word_valid && bus.word_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%0h required none", bus.word_out);
          end else begin
            mon_e = exp_q.pop_front();
            check("word_out", bus.word_out, mon_e.word);
            check("parity_err", bus.parity_err, mon_e.perr);
          end
        end
        hold_prev = bus.word_valid && !bus.word_ready;
        hold_word = bus.word_out;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic shift_bit(input logic b, input int gap);
    bus.serial_in = b;
    bus.bit_en    = 1'b1;
    tick();
    bus.bit_en    = 1'b0;
    repeat (gap) tick();
  endtask

  // Full frame; gap idle cycles between bit_en strobes; returns right after the final bit edge
  task automatic send_frame(input logic [W-1:0] w, input int gap, input logic pbit);
    int last_gap;
    start_frame();
    for (int i = W - 1; i >= 0; i--) begin
      if (!bus.busy) busy_low++;
`ifdef SIPO_PARITY_CHECK_EN
      last_gap = gap;
`else
      last_gap = (i == 0) ? 0 : gap;
`endif
      shift_bit(w[i], last_gap);
    end
`ifdef SIPO_PARITY_CHECK_EN
    if (!bus.busy) busy_low++;
    shift_bit(pbit, 0);
`else
    bus.serial_in = pbit;
`endif
  endtask

  task automatic push_exp(input logic [W-1:0] w, input logic pbit);
    exp_t e;
    e.word = w;
    e.perr = exp_perr(w, pbit);
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((exp_q.size() != 0 || bus.word_valid) && n < max) begin
      tick();
      n++;
    end
    check(name, (n < max) ? 64'd1 : 64'd0, 64'd1);
  endtask

  logic [W-1:0] v;
  int           ov0;
  int           n;

  initial begin
    bus.serial_in   = 1'b0;
    bus.bit_en      = 1'b0;
    bus.frame_start = 1'b0;
    bus.word_ready  = 1'b0;

    // 1. reset state
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    check("rst_word_out", bus.word_out, 32'h0);
    check("rst_valid", bus.word_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_overrun", bus.overrun, 1'b0);
    check("rst_parity_err", bus.parity_err, 1'b0);

    // 2. back-to-back bits, ready high
    bus.word_ready = 1'b1;
    v = 32'hA5A5_0F0F;
    push_exp(v, ^v);
    send_frame(v, 0, ^v);
    n = 0;
    while (!bus.word_valid && n < 2) begin
      tick();
      n++;
    end
    check("latency_valid", bus.word_valid, 1'b1);
    check("latency_word", bus.word_out, v);
    tick();
    check("ready_clears_valid", bus.word_valid, 1'b0);
    wait_drain("drain_t2", 10);

    // 3. bit_en every 3rd cycle, busy over the whole frame
    v = 32'h8000_0001;
    busy_low = 0;
    push_exp(v, ^v);
    send_frame(v, 2, ^v);
    check("busy_frame", busy_low, 0);
    wait_drain("drain_t3", 10);

    // 4a. commit into a full buffer drops the new word
    bus.word_ready = 1'b0;
    v = 32'h1234_5678;
    push_exp(v, ^v);
    send_frame(v, 0, ^v);
    repeat (3) tick();
    check("held_valid", bus.word_valid, 1'b1);
    ov0 = overrun_seen;
    send_frame(32'hFFFF_FFFF, 0, 1'b0);
    repeat (3) tick();
    check("overrun_pulse", overrun_seen - ov0, 1);
    check("held_word_kept", bus.word_out, 32'h1234_5678);
    bus.word_ready = 1'b1;
    wait_drain("drain_t4a", 10);

    // 4b. commit together with a handshake loads the new word
    bus.word_ready = 1'b0;
    push_exp(v, ^v);
    send_frame(v, 0, ^v);
    repeat (2) tick();
    ov0 = overrun_seen;
    push_exp(32'hFFFF_FFFF, 1'b0);
    send_frame(32'hFFFF_FFFF, 0, 1'b0);
    bus.word_ready = 1'b1;
    tick();
    check("swap_word", bus.word_out, 32'hFFFF_FFFF);
    wait_drain("drain_t4b", 10);
    check("no_overrun", overrun_seen - ov0, 0);

    // 5a. restart after 10 bits discards the partial frame
    start_frame();
    for (int i = 0; i < 10; i++) shift_bit(1'b1, 0);
    v = 32'h0000_00FF;
    push_exp(v, ^v);
    send_frame(v, 0, ^v);
    wait_drain("drain_t5a", 10);

    // 5b. reset at bit 20 with a word also held: everything discarded
    bus.word_ready = 1'b0;
    v = 32'hCAFE_F00D;
    push_exp(v, ^v);
    send_frame(v, 0, ^v);
    start_frame();
    for (int i = 0; i < 20; i++) shift_bit(1'b0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    check("midrst_valid", bus.word_valid, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_word", bus.word_out, 32'h0);
    bus.word_ready = 1'b1;
    repeat (40) tick();
    check("midrst_no_word", bus.word_valid, 1'b0);

`ifdef SIPO_PARITY_CHECK_EN
    // 6. even parity: good bit then bad bit, word delivered both times
    push_exp(32'h0000_0007, 1'b1);
    send_frame(32'h0000_0007, 0, 1'b1);
    wait_drain("drain_t6a", 10);
    push_exp(32'h0000_0007, 1'b0);
    send_frame(32'h0000_0007, 0, 1'b0);
    wait_drain("drain_t6b", 10);
`endif

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    check("overrun_total", overrun_seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
